// File: rtl/apb_req_master_if.sv
// apb_req_master_if: bundles the request/response stream and the APB4 bus of
// apb_req_master into one interface.
//   req_*   : single-beat request stream (valid/ready) into the requester
//   rsp_*   : one-cycle response pulse out of the requester
//   P*      : APB4 master-side signals towards the slave
// Modports:
//   master : the requester's view (drives req_ready, rsp_*, PSEL..PSTRB)
//   slave  : the environment's view (drives req_*, PREADY, PRDATA, PSLVERR)
interface apb_req_master_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  // Request stream
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_strb;

  // Response pulse
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB4
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PREADY, PRDATA, PSLVERR,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PREADY, PRDATA, PSLVERR,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_req_master.sv
// apb_req_master: upstream APB4 requester. Turns a valid/ready single-beat request
// stream into one SETUP/ACCESS transfer at a time and returns a one-cycle response
// pulse per transfer. An ACCESS-phase watchdog terminates transfers whose slave never
// raises PREADY (TIMEOUT = 0 disables it).
// Ports:
//   PCLK     : clock, rising edge
//   PRESETn  : synchronous active-low reset
//   bus      : apb_req_master_if.master -- request stream in, response pulse out,
//              APB4 master signals out, PREADY/PRDATA/PSLVERR in
// All APB and response outputs are registered; req_ready decodes the state register.
module apb_req_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic                PCLK,
  input logic                PRESETn,
  apb_req_master_if.master   bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  // Watchdog sized to hold TIMEOUT; keep at least one bit when disabled.
  localparam int unsigned WdWidth  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          WdEnable = (TIMEOUT != 0);
  // Value the watchdog holds on the last permitted ACCESS cycle.
  localparam logic [WdWidth-1:0] WdLast = WdWidth'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [WdWidth-1:0] WdMax  = {WdWidth{1'b1}};

  logic [1:0]            state_q,     state_d;
  logic [WdWidth-1:0]    wd_q,        wd_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,     pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic                  wd_expired;

  // Timeout fires on the ACCESS cycle where the watchdog would reach TIMEOUT.
  assign wd_expired = WdEnable && (wd_q == WdLast);

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          pwrite_d  = bus.req_write;
          paddr_d   = bus.req_addr;
          pwdata_d  = bus.req_wdata;
          // Reads never carry strobes onto the bus.
          pstrb_d   = bus.req_write ? bus.req_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        penable_d = 1'b1;
        wd_d      = '0;
        state_d   = StAccess;
      end

      StAccess: begin
        if (bus.PREADY) begin
          // PREADY has priority over a watchdog expiring in the same cycle.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          state_d     = StIdle;
        end else if (wd_expired) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = StIdle;
        end else begin
          // Saturate rather than wrap so a disabled watchdog stays harmless.
          wd_d = (wd_q == WdMax) ? wd_q : wd_q + WdWidth'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;

  // Protocol sanity checks (ignored by synthesis).
  a_enable_needs_sel : assert property (@(posedge PCLK) penable_q |-> psel_q);
  a_rsp_one_cycle    : assert property (@(posedge PCLK) rsp_valid_q |=> !rsp_valid_q);
  a_setup_stable     : assert property (@(posedge PCLK)
      (PRESETn && state_q == StSetup) |=> ($stable(paddr_q) && $stable(pwdata_q) &&
                                           $stable(pstrb_q) && $stable(pwrite_q)));

endmodule
